// File: rtl/specific_seq_pkg.sv
// Shared constants, state encoding and code helpers for the specific-sequence checker.
package specific_seq_pkg;

  localparam logic [2:0] SEQ_C0 = 3'b000;
  localparam logic [2:0] SEQ_C1 = 3'b001;
  localparam logic [2:0] SEQ_C2 = 3'b011;
  localparam logic [2:0] SEQ_C3 = 3'b101;
  localparam logic [2:0] SEQ_C4 = 3'b111;
  localparam logic [2:0] SEQ_C5 = 3'b010;

  localparam logic [2:0] SEQ_IDX_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    StHunt,
    StTrack,
    StLocked
  } seq_state_e;

  // Illegal codes map to SEQ_C0 so callers never see X.
  function automatic logic [2:0] seq_succ(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      SEQ_C0:  nxt = SEQ_C1;
      SEQ_C1:  nxt = SEQ_C2;
      SEQ_C2:  nxt = SEQ_C3;
      SEQ_C3:  nxt = SEQ_C4;
      SEQ_C4:  nxt = SEQ_C5;
      SEQ_C5:  nxt = SEQ_C0;
      default: nxt = SEQ_C0;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] seq_index(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      SEQ_C0:  idx = 3'd0;
      SEQ_C1:  idx = 3'd1;
      SEQ_C2:  idx = 3'd2;
      SEQ_C3:  idx = 3'd3;
      SEQ_C4:  idx = 3'd4;
      SEQ_C5:  idx = 3'd5;
      default: idx = SEQ_IDX_ILLEGAL;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/specific_seq_decode.sv
// Combinational classification of a sampled code against the previously accepted code.
module specific_seq_decode
  import specific_seq_pkg::*;
(
  input  logic [2:0] code_i,
  input  logic [2:0] prev_i,
  output logic [2:0] index_o,
  output logic       is_illegal_o,
  output logic       is_succ_o,
  output logic       is_hold_o
);

  assign index_o      = seq_index(code_i);
  assign is_illegal_o = (index_o == SEQ_IDX_ILLEGAL);
  assign is_succ_o    = !is_illegal_o && (code_i == seq_succ(prev_i));
  assign is_hold_o    = !is_illegal_o && (code_i == prev_i);

endmodule

// File: rtl/specific_sequence_checker.sv
// Receive-side monitor for the 000-001-011-101-111-010 count sequence: lock FSM,
// transition error detection and saturating error/wrap counters.
module specific_sequence_checker
  import specific_seq_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned LOSS_COUNT = 2,
  parameter bit          HOLD_OK    = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [2:0]       in_code_i,
  output logic             locked_o,
  output logic [2:0]       index_o,
  output logic [2:0]       expected_o,
  output logic             seq_err_o,
  output logic             illegal_code_o,
  output logic             wrap_pulse_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] wrap_count_o
);

  localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LossW = $clog2(LOSS_COUNT + 1);

  seq_state_e       state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [RunW-1:0]  good_run_q, good_run_d;
  logic [LossW-1:0] bad_run_q, bad_run_d;
  logic [2:0]       index_q, index_d;
  logic             seq_err_q, seq_err_d;
  logic             illegal_q, illegal_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [2:0] dec_index;
  logic       dec_illegal, dec_succ, dec_hold, is_good;

  specific_seq_decode u_decode (
    .code_i       (in_code_i),
    .prev_i       (prev_q),
    .index_o      (dec_index),
    .is_illegal_o (dec_illegal),
    .is_succ_o    (dec_succ),
    .is_hold_o    (dec_hold)
  );

  assign is_good = dec_succ || (HOLD_OK && dec_hold);

  // prev only ever takes legal codes, so the decoder always compares against a real position.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    index_d    = index_q;
    seq_err_d  = 1'b0;
    illegal_d  = 1'b0;
    wrap_d     = 1'b0;
    if (in_valid_i) begin
      index_d   = dec_index;
      illegal_d = dec_illegal;
      unique case (state_q)
        StHunt: begin
          if (!dec_illegal) begin
            prev_d     = in_code_i;
            good_run_d = '0;
            state_d    = StTrack;
          end
        end
        StTrack: begin
          if (is_good) begin
            prev_d = in_code_i;
            if (dec_succ) begin
              good_run_d = good_run_q + RunW'(1);
              if (good_run_q == RunW'(LOCK_COUNT - 1)) begin
                state_d   = StLocked;
                bad_run_d = '0;
              end
            end
          end else begin
            seq_err_d = 1'b1;
            state_d   = StHunt;
            if (!dec_illegal) prev_d = in_code_i;
          end
        end
        StLocked: begin
          if (is_good) begin
            bad_run_d = '0;
            prev_d    = in_code_i;
            wrap_d    = dec_succ && (prev_q == SEQ_C5);
          end else begin
            seq_err_d = 1'b1;
            if (!dec_illegal) prev_d = in_code_i;
            if (bad_run_q == LossW'(LOSS_COUNT - 1)) begin
              state_d   = StHunt;
              bad_run_d = '0;
            end else begin
              bad_run_d = bad_run_q + LossW'(1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (seq_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_d && (wrap_cnt_q != '1)) wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StHunt;
      prev_q     <= SEQ_C0;
      good_run_q <= '0;
      bad_run_q  <= '0;
      index_q    <= '0;
      seq_err_q  <= 1'b0;
      illegal_q  <= 1'b0;
      wrap_q     <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
      index_q    <= index_d;
      seq_err_q  <= seq_err_d;
      illegal_q  <= illegal_d;
      wrap_q     <= wrap_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign locked_o       = (state_q == StLocked);
  assign index_o        = index_q;
  assign expected_o     = (state_q == StHunt) ? SEQ_C0 : seq_succ(prev_q);
  assign seq_err_o      = seq_err_q;
  assign illegal_code_o = illegal_q;
  assign wrap_pulse_o   = wrap_q;
  assign err_count_o    = err_cnt_q;
  assign wrap_count_o   = wrap_cnt_q;

endmodule
